div_sign_ctrl: RTL and testbench
================================

# div_sign_ctrl

Signed/unsigned divide control stage wrapped around the 32-bit unsigned pipelined divider in the execute path.
- Upstream half: converts RISC-V M-extension DIV/DIVU/REM/REMU operands to unsigned magnitudes and drives them into the divider.
- Shadow pipeline: carries per-op metadata (valid, op, tag, sign fix-up flags) alongside the divider, DIV_LATENCY deep.
- Downstream half: selects quotient or remainder, applies sign correction and RISC-V corner-case rules, and registers the writeback result.
- Throughput: one op per cycle, no backpressure.

## Interface
Parameters:
- DIV_LATENCY, 2, cycles from operands driven on o_div_* to the matching result on i_div_*; legal range ≥1.
- TAG_W, 5, width of the destination tag carried with each op.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  op presented this cycle.
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_rs1  in  32  dividend.
- i_rs2  in  32  divisor.
- i_tag  in  TAG_W  destination tag.
- i_flush  in  1  kill all in-flight ops.
- o_div_dividend  out  32  magnitude dividend to divider (combinational).
- o_div_divisor  out  32  magnitude divisor to divider (combinational).
- i_div_quotient  in  32  divider quotient.
- i_div_remainder  in  32  divider remainder.
- o_valid  out  1  result valid.
- o_result  out  32  writeback value.
- o_tag  out  TAG_W  tag of result.
- o_div0_count  out  16  divide-by-zero completions (see Configuration).

## Operation
Magnitudes, computed combinationally from inputs:
- Signed ops (DIV, REM): negative operands are two's-complement negated.
- 0x80000000 maps to 0x80000000; no special case needed.
- Unsigned ops pass operands through unchanged.

Metadata captured per op:
- valid, op, tag.
- neg_q = signed & (rs1[31]^rs2[31]) & (rs2!=0).
- neg_r = signed & rs1[31].
- div0 = (rs2==0).

Shift pipeline:
- Metadata moves through a DIV_LATENCY-entry shift register every cycle, unconditionally.
- Entry 0 loads {i_valid & ~i_flush, ...}.
- The tail entry is aligned with i_div_*.

Fix-up at the tail:
- REM/REMU select the remainder; DIV/DIVU select the quotient.
- The selected value is negated when neg_q (DIV) or neg_r (REM) is set.

Required corner results (these fall out of the rules above; the bench checks them explicitly):
- x/0: quotient 0xFFFFFFFF for DIV and DIVU; remainder = rs1 for REM and REMU.
- DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same = 0.

Flush:
- i_flush clears every in-flight valid bit, including the output register, on the same edge.
- i_valid together with i_flush drops the new op.

Reset:
- All valid bits, o_valid, o_result, o_tag and o_div0_count go to 0.
- Ops in flight are lost.
- Payload (non-valid) metadata fields need not be reset.

## Timing
- Op sampled at edge T; o_div_* reflect it during the cycle before edge T.
- Result appears on i_div_* DIV_LATENCY cycles later.
- o_valid/o_result/o_tag are registered and assert DIV_LATENCY+1 cycles after the op is sampled (3 cycles at default).
- Back-to-back ops produce back-to-back results in issue order.
- o_result and o_tag hold their last values when o_valid=0.
- o_valid is a single-cycle pulse per op.
- Reset asserted mid-stream: outputs drop to 0 asynchronously.
- First op after reset deassertion follows normal latency.

## Configuration
- DIV_STATS_EN defined: o_div0_count increments at each edge where a valid, unflushed op with div0=1 is written to the output register.
  - Saturates at 0xFFFF.
  - Cleared only by rst.
- Not defined: no counter logic; o_div0_count tied to 0.

## Test plan
- DIVU 100 / 7 tag 3 -> after 3 cycles o_valid=1, o_result=14, o_tag=3; REMU same operands -> 2.
- DIV -7 / 2 -> 0xFFFFFFFD (−3); REM -7 / 2 -> 0xFFFFFFFF (−1); REM 7 / -2 -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF; REM -5 / 0 -> 0xFFFFFFFB; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
  - With DIV_STATS_EN: o_div0_count=2 after these.
- Five back-to-back mixed ops, tags 1..5 -> five consecutive o_valid cycles, tags in order 1..5, results match reference model.
- Issue ops tags 1,2; assert i_flush on the cycle after tag 2 -> no o_valid for either.
  - Op issued in the following cycle completes normally.
- Assert rst asynchronously with 2 ops in flight -> o_valid=0 immediately.
  - No stale result after reset release.
  - o_div0_count=0.

Source files
------------

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned divide control wrapped around a DIV_LATENCY-cycle unsigned divider.
// Optional divide-by-zero completion counter enabled by defining DIV_STATS_EN.
module div_sign_ctrl #(
  parameter int DIV_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic [31:0]      o_div_dividend,
  output logic [31:0]      o_div_divisor,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic [15:0]      o_div0_count
);

  typedef struct packed {
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
  } meta_t;

  // op[0] clear means signed (DIV, REM)
  logic is_signed;
  logic rs1_neg;
  logic rs2_neg;
  logic rs2_zero;

  assign is_signed = ~i_op[0];
  assign rs1_neg   = is_signed & i_rs1[31];
  assign rs2_neg   = is_signed & i_rs2[31];
  assign rs2_zero  = (i_rs2 == 32'd0);

  assign o_div_dividend = rs1_neg ? (~i_rs1 + 32'd1) : i_rs1;
  assign o_div_divisor  = rs2_neg ? (~i_rs2 + 32'd1) : i_rs2;

  meta_t meta_new;
  assign meta_new.op    = i_op;
  assign meta_new.tag   = i_tag;
  assign meta_new.neg_q = is_signed & (i_rs1[31] ^ i_rs2[31]) & ~rs2_zero;
  assign meta_new.neg_r = rs1_neg;
  assign meta_new.div0  = rs2_zero;

  // Shadow pipeline: stage inputs are built per stage, then registered as a whole.
  logic [DIV_LATENCY-1:0] valid_reg;
  logic [DIV_LATENCY-1:0] valid_next;
  meta_t                  meta_reg  [DIV_LATENCY];
  meta_t                  meta_next [DIV_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < DIV_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = i_valid & ~i_flush;
        assign meta_next[gi]  = meta_new;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1] & ~i_flush;
        assign meta_next[gi]  = meta_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    meta_reg <= meta_next;
  end

  // Tail stage lines up with the divider's outputs.
  meta_t       tail_meta;
  logic        tail_write;
  logic [31:0] sel_value;
  logic        sel_neg;
  logic [31:0] fix_result;

  assign tail_meta  = meta_reg[DIV_LATENCY-1];
  assign tail_write = valid_reg[DIV_LATENCY-1] & ~i_flush;
  assign sel_value  = tail_meta.op[1] ? i_div_remainder : i_div_quotient;
  assign sel_neg    = tail_meta.op[1] ? tail_meta.neg_r : tail_meta.neg_q;
  assign fix_result = sel_neg ? (~sel_value + 32'd1) : sel_value;

  logic             valid_out_reg;
  logic [31:0]      result_reg;
  logic [TAG_W-1:0] tag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      result_reg    <= 32'd0;
      tag_reg       <= '0;
    end else begin
      valid_out_reg <= tail_write;
      if (tail_write) begin
        result_reg <= fix_result;
        tag_reg    <= tail_meta.tag;
      end
    end
  end

  assign o_valid  = valid_out_reg;
  assign o_result = result_reg;
  assign o_tag    = tag_reg;

`ifdef DIV_STATS_EN
  logic [15:0] div0_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div0_count_reg <= 16'd0;
    end else if (tail_write && tail_meta.div0 && (div0_count_reg != 16'hFFFF)) begin
      div0_count_reg <= div0_count_reg + 16'd1;
    end
  end

  assign o_div0_count = div0_count_reg;
`else
  logic unused_div0;
  assign unused_div0  = tail_meta.div0;
  assign o_div0_count = 16'd0;
`endif

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Self-checking bench for div_sign_ctrl: directed vector table, flush/reset sequences,
// and randomized ops scored against a RISC-V division reference model.
module tb_div_sign_ctrl;
  localparam int L     = 2;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic [1:0]       i_op;
  logic [31:0]      i_rs1;
  logic [31:0]      i_rs2;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic [31:0]      div_quotient;
  logic [31:0]      div_remainder;
  logic             o_valid;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic [15:0]      o_div0_count;

  div_sign_ctrl #(.DIV_LATENCY(L), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_tag(i_tag), .i_flush(i_flush), .o_div_dividend(div_dividend),
    .o_div_divisor(div_divisor), .i_div_quotient(div_quotient),
    .i_div_remainder(div_remainder), .o_valid(o_valid), .o_result(o_result),
    .o_tag(o_tag), .o_div0_count(o_div0_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned divider model with L cycles of latency.
  logic [31:0] dly_a [L];
  logic [31:0] dly_b [L];
  always @(posedge clk) begin
    dly_a[0] <= div_dividend;
    dly_b[0] <= div_divisor;
    for (int k = 1; k < L; k++) begin
      dly_a[k] <= dly_a[k-1];
      dly_b[k] <= dly_b[k-1];
    end
  end
  assign div_quotient  = (dly_b[L-1] == 32'd0) ? 32'hFFFFFFFF : dly_a[L-1] / dly_b[L-1];
  assign div_remainder = (dly_b[L-1] == 32'd0) ? dly_a[L-1]   : dly_a[L-1] % dly_b[L-1];

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFFFFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  typedef struct {
    int              due;
    logic [31:0]     res;
    logic [TAG_W-1:0] tag;
    logic            div0;
  } exp_t;

  exp_t             sb_q[$];
  logic [31:0]      last_res;
  logic [TAG_W-1:0] last_tag;
  int               exp_cnt;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_t e;
    exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
    check("o_valid", 32'(o_valid), 32'(exp_v));
    if (exp_v) begin
      e        = sb_q.pop_front();
      last_res = e.res;
      last_tag = e.tag;
`ifdef DIV_STATS_EN
      if (e.div0 && exp_cnt < 16'hFFFF) exp_cnt++;
`endif
      $display("result tag=%0d value=%h (cycle %0d)", o_tag, o_result, cyc);
    end
    check("o_result", o_result, last_res);
    check("o_tag", 32'(o_tag), 32'(last_tag));
    check("o_div0_count", 32'(o_div0_count), 32'(exp_cnt));
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic fl,
                      input logic [31:0] exp_res);
    exp_t e;
    @(negedge clk);
    check_outputs();
    i_valid = v;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_tag   = tag;
    i_flush = fl;
    if (fl) sb_q.delete();
    if (v && !fl) begin
      e.due  = cyc + L + 1;
      e.res  = exp_res;
      e.tag  = tag;
      e.div0 = (b == 32'd0);
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'd0, 32'd0, '0, 1'b0, 32'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    step(1'b1, op, a, b, tag, 1'b0, ref_model(op, a, b));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b01, 32'd100,        32'd7,          5'd3, 32'd14};
    vecs[1] = '{2'b11, 32'd100,        32'd7,          5'd4, 32'd2};
    vecs[2] = '{2'b00, 32'hFFFFFFF9,   32'd2,          5'd5, 32'hFFFFFFFD};
    vecs[3] = '{2'b10, 32'hFFFFFFF9,   32'd2,          5'd6, 32'hFFFFFFFF};
    vecs[4] = '{2'b10, 32'd7,          32'hFFFFFFFE,   5'd7, 32'd1};
    vecs[5] = '{2'b00, 32'd5,          32'd0,          5'd8, 32'hFFFFFFFF};
    vecs[6] = '{2'b10, 32'hFFFFFFFB,   32'd0,          5'd9, 32'hFFFFFFFB};
    vecs[7] = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000};
    vecs[8] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0};

    rst = 1'b1; i_valid = 0; i_op = 0; i_rs1 = 0; i_rs2 = 0; i_tag = 0; i_flush = 0;
    last_res = 0; last_tag = 0; exp_cnt = 0;
    repeat (2) @(negedge clk);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_result", o_result, 32'd0);
    check("reset o_tag", 32'(o_tag), 32'd0);
    check("reset o_div0_count", 32'(o_div0_count), 32'd0);
    rst = 1'b0;

    // Isolated first op: exact latency check.
    step(1'b1, vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].tag, 1'b0, vecs[0].exp);
    idle(L + 2);

    // Directed table, back to back.
    for (int i = 0; i < 9; i++)
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, vecs[i].exp);
    idle(L + 2);
`ifdef DIV_STATS_EN
    check("div0 count after table", 32'(o_div0_count), 32'd2);
`else
    check("div0 count after table", 32'(o_div0_count), 32'd0);
`endif

    // Five back-to-back mixed ops, tags 1..5.
    for (int i = 1; i <= 5; i++) issue(2'(i), pick(), pick(), 5'(i));
    idle(L + 2);

    // Flush on the cycle after tag 2; an op alongside the flush is dropped too.
    issue(2'b01, 32'd50, 32'd5, 5'd1);
    issue(2'b00, 32'd60, 32'd0, 5'd2);
    step(1'b1, 2'b01, 32'd9, 32'd3, 5'd12, 1'b1, 32'd3);
    issue(2'b10, 32'hFFFFFFF0, 32'd3, 5'd13);
    idle(L + 2);

    // Asynchronous reset with two ops still in flight.
    issue(2'b01, 32'd30, 32'd4, 5'd14);
    issue(2'b00, 32'd31, 32'd0, 5'd15);
    issue(2'b11, 32'd32, 32'd5, 5'd16);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("async rst o_valid", 32'(o_valid), 32'd0);
    check("async rst o_result", o_result, 32'd0);
    check("async rst o_tag", 32'(o_tag), 32'd0);
    check("async rst o_div0_count", 32'(o_div0_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    last_res = 0; last_tag = 0; exp_cnt = 0;
    idle(L + 3);
    issue(2'b00, 32'hFFFFFF9C, 32'd7, 5'd17);
    idle(L + 2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      step($urandom_range(0, 3) != 0, op, a, b, 5'($urandom), $urandom_range(0, 19) == 0,
           ref_model(op, a, b));
    end
    idle(L + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
